stack_arb_2x: RTL and testbench



---
 rtl/stack_arb_pkg.sv | 20 ++
 rtl/stack_arb_2x_rr_arb2.sv | 49 ++++
 rtl/stack_arb_2x.sv | 137 +++++++++++++
 tb/tb_stack_arb_2x.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg
// Shared definitions for the two-requester stack arbiter:
//   - OP_PUSH / OP_POP : request opcode encodings
//   - req_id_t         : requester identifier (0 or 1)
//   - ERR_*            : bit positions of the individual consistency checks
//                        that feed the sticky err flag
package stack_arb_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef logic req_id_t;

  localparam int ERR_NUM            = 4;
  localparam int ERR_ORPHAN_RSP     = 0;  // stack returned data nobody asked for
  localparam int ERR_LOST_RSP       = 1;  // a pop was issued but no data came back
  localparam int ERR_EMPTY_MISMATCH = 2;  // our count and the stack disagree on empty
  localparam int ERR_FULL_MISMATCH  = 3;  // our count and the stack disagree on full

endpackage

// File: rtl/stack_arb_2x_rr_arb2.sv
// rr_arb2
// Two-input arbiter. Grants at most one eligible input per cycle.
// Configuration macro STACK_ARB_RR_EN:
//   defined   : round-robin; on a tie the input not granted most recently wins.
//               The pointer holds the id of the last granted input and resets to
//               1 so that input 0 is favoured first.
//   undefined : fixed priority, input 0 always wins; no state, no clock ports.
// Ports:
//   clk, reset : clock and synchronous active-high reset (round-robin build only)
//   elig[1:0]  : per-input eligibility
//   gnt[1:0]   : one-hot (or zero) grant
module rr_arb2
  import stack_arb_pkg::*;
(
`ifdef STACK_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

`ifdef STACK_ARB_RR_EN
  req_id_t ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b1;
    end else if (|gnt) begin
      ptr_reg <= gnt[1];
    end
  end

  always_comb begin
    gnt = elig;
    if (&elig) begin
      gnt = ptr_reg ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    gnt = elig;
    if (elig[0]) begin
      gnt[1] = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/stack_arb_2x.sv
// stack_arb_2x
// Arbiter/sequencer placing two requesters in front of one M x N stack.
// One push or pop is issued per cycle; popped data is steered back to the
// requester that issued the pop one cycle later. An independent occupancy count
// is kept and compared against the stack's full/empty flags and response timing;
// any divergence sets the sticky err output.
// Configuration macro STACK_ARB_RR_EN: round-robin arbitration when defined,
// fixed priority (requester 0 wins) otherwise.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   reqX_valid/op/data, reqX_ready  : requester handshakes (ready is combinational)
//   rsp0_valid, rsp1_valid, rsp_data: pop responses (shared data bus)
//   stk_push, stk_pop, stk_push_data: commands to the stack
//   stk_full, stk_empty, stk_valid, stk_pop_data : status/data from the stack
//   level                           : controller occupancy count
//   err                             : sticky consistency error
module stack_arb_2x
  import stack_arb_pkg::*;
#(
  parameter int M     = 128,
  parameter int N     = 8,
  parameter int WIDTH = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic           req0_op,
  input  logic [N-1:0]   req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic           req1_op,
  input  logic [N-1:0]   req1_data,
  output logic           req1_ready,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [N-1:0]   rsp_data,
  output logic           stk_push,
  output logic           stk_pop,
  output logic [N-1:0]   stk_push_data,
  input  logic           stk_full,
  input  logic           stk_empty,
  input  logic           stk_valid,
  input  logic [N-1:0]   stk_pop_data,
  output logic [WIDTH:0] level,
  output logic           err
);

  localparam logic [WIDTH:0] LVL_ONE = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0] LVL_MAX = (WIDTH + 1)'(M);

  logic [1:0]         req_valid;
  logic [1:0]         req_op;
  logic [N-1:0]       req_data [2];
  logic [1:0]         elig;
  logic [1:0]         gnt;
  logic [1:0]         rsp_valid;
  req_id_t            sel;
  logic [WIDTH:0]     level_reg;
  logic [WIDTH:0]     level_next;
  logic               pend_vld_reg;
  req_id_t            pend_id_reg;
  logic               err_reg;
  logic [ERR_NUM-1:0] err_cause;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_op      = {req1_op, req0_op};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // Eligibility is judged per requester so a blocked one never stalls the other.
  // Nothing is granted while reset is high: the stack is held in reset too.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign elig[gi] = !reset && req_valid[gi] &&
                      ((req_op[gi] == OP_PUSH) ? !stk_full : !stk_empty);
    // A response already in flight when reset arrives is dropped.
    assign rsp_valid[gi] = !reset && stk_valid && pend_vld_reg &&
                           (pend_id_reg == req_id_t'(gi));
  end

  rr_arb2 u_arb (
`ifdef STACK_ARB_RR_EN
    .clk   (clk),
    .reset (reset),
`endif
    .elig  (elig),
    .gnt   (gnt)
  );

  assign sel        = gnt[1];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Only one request is granted, so push and pop are mutually exclusive.
  assign stk_push      = (|gnt) && (req_op[sel] == OP_PUSH);
  assign stk_pop       = (|gnt) && (req_op[sel] == OP_POP);
  assign stk_push_data = stk_push ? req_data[sel] : '0;

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp_data   = reset ? '0 : stk_pop_data;

  always_comb begin
    level_next = level_reg;
    if (stk_push) begin
      level_next = level_reg + LVL_ONE;
    end else if (stk_pop) begin
      level_next = level_reg - LVL_ONE;
    end
  end

  // All checks use pre-edge state on both sides, so they line up cycle by cycle.
  always_comb begin
    err_cause                     = '0;
    err_cause[ERR_ORPHAN_RSP]     = stk_valid && !pend_vld_reg;
    err_cause[ERR_LOST_RSP]       = pend_vld_reg && !stk_valid;
    err_cause[ERR_EMPTY_MISMATCH] = (level_reg == '0) != stk_empty;
    err_cause[ERR_FULL_MISMATCH]  = (level_reg >= LVL_MAX) != stk_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg    <= '0;
      pend_vld_reg <= 1'b0;
      pend_id_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      level_reg    <= level_next;
      pend_vld_reg <= stk_pop;
      pend_id_reg  <= sel;
      err_reg      <= err_reg || (|err_cause);
    end
  end

  assign level = level_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_stack_arb_2x.sv
// tb_stack_arb_2x
// Bench for stack_arb_2x: contains a behavioural stack (the part the integrator
// would instantiate), a queue-based reference model that predicts every output
// each cycle, directed scenarios with literal expectations, and a random phase.
module tb_stack_arb_2x;

  localparam int M = 128;
  localparam int N = 8;
  localparam int WIDTH = 7;
`ifdef STACK_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req0_op = 1'b0, req1_valid = 1'b0, req1_op = 1'b0;
  logic [N-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_data, stk_push_data, stk_pop_data;
  logic stk_push, stk_pop, stk_full, stk_empty, stk_valid;
  logic [WIDTH:0] level;
  logic err;
  logic force_valid = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  stack_arb_2x #(.M(M), .N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_push_data(stk_push_data),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_valid(stk_valid),
    .stk_pop_data(stk_pop_data), .level(level), .err(err)
  );

  // ---------------- behavioural stack ----------------
  logic [N-1:0] smem [M];
  int sp;
  logic s_valid;
  logic [N-1:0] s_data;

  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
      s_valid <= 1'b0;
      s_data <= '0;
    end else begin
      s_valid <= 1'b0;
      if (stk_push && sp < M) begin
        smem[sp] <= stk_push_data;
        sp <= sp + 1;
      end else if (stk_pop && sp > 0) begin
        s_data <= smem[sp-1];
        s_valid <= 1'b1;
        sp <= sp - 1;
      end
    end
  end

  assign stk_full = (sp == M);
  assign stk_empty = (sp == 0);
  assign stk_valid = s_valid | force_valid;
  assign stk_pop_data = s_data;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: stack contents as a queue, outstanding pop, sticky error,
  // and the id of the last granted requester.
  logic [N-1:0] mq[$];
  bit m_known = 1'b0;
  bit m_pvld = 1'b0;
  bit m_pid = 1'b0;
  logic [N-1:0] m_pdata = '0;
  bit m_err = 1'b0;
  bit m_last = 1'b1;

  always @(negedge clk) begin
    bit e0, e1, g0, g1, xpush, xpop, nerr;
    logic [N-1:0] xdata;
    if (reset) begin
      chk("ready0_rst", req0_ready, 0);
      chk("ready1_rst", req1_ready, 0);
      chk("push_rst", stk_push, 0);
      chk("pop_rst", stk_pop, 0);
      chk("rsp0_rst", rsp0_valid, 0);
      chk("rsp1_rst", rsp1_valid, 0);
      if (m_known) begin
        chk("level_rst", level, mq.size());
        chk("err_rst", err, m_err);
      end
      mq.delete();
      m_pvld = 0; m_pid = 0; m_err = 0; m_last = 1; m_known = 1;
    end else if (m_known) begin
      e0 = req0_valid && ((req0_op == 1'b0) ? (mq.size() < M) : (mq.size() > 0));
      e1 = req1_valid && ((req1_op == 1'b0) ? (mq.size() < M) : (mq.size() > 0));
      if (e0 && e1) begin
        g0 = RR ? (m_last == 1'b1) : 1'b1;
      end else begin
        g0 = e0;
      end
      g1 = e1 && !g0;
      xpush = (g0 && req0_op == 1'b0) || (g1 && req1_op == 1'b0);
      xpop  = (g0 && req0_op == 1'b1) || (g1 && req1_op == 1'b1);
      xdata = g1 ? req1_data : req0_data;
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      chk("stk_push", stk_push, xpush);
      chk("stk_pop", stk_pop, xpop);
      if (xpush) chk("push_data", stk_push_data, xdata);
      chk("rsp0_valid", rsp0_valid, m_pvld && m_pid == 1'b0);
      chk("rsp1_valid", rsp1_valid, m_pvld && m_pid == 1'b1);
      if (m_pvld) chk("rsp_data", rsp_data, m_pdata);
      chk("level", level, mq.size());
      chk("err", err, m_err);
      nerr = m_err || (force_valid && !m_pvld);
      if (xpush) mq.push_back(xdata);
      if (xpop) begin
        m_pdata = mq.pop_back();
        m_pvld = 1;
        m_pid = g1;
      end else begin
        m_pvld = 0;
      end
      if (g0 || g1) m_last = g1;
      m_err = nerr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v0, input bit op0, input logic [N-1:0] d0,
                       input bit v1, input bit op1, input logic [N-1:0] d1);
    req0_valid = v0; req0_op = op0; req0_data = d0;
    req1_valid = v1; req1_op = op1; req1_data = d1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) next();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] lit [3];
    int pp;
    lit[0] = 8'h11; lit[1] = 8'h22; lit[2] = 8'h33;
    repeat (3) next();
    reset = 1'b0;

    // LIFO order through requester 0
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, lit[i], 0, 0, 0);
      @(negedge clk); chk("t1_push_ready", req0_ready, 1);
      next();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 1, 0, 0, 0, 0); else drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i == 0) chk("t1_level3", level, 3);
      if (i > 0) begin
        chk("t1_rsp0", rsp0_valid, 1);
        chk("t1_data", rsp_data, lit[3-i]);
      end
      if (i == 3) begin
        chk("t1_level0", level, 0);
        chk("t1_err", err, 0);
      end
      next();
    end

    // both push every cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'($urandom), 1, 0, 8'($urandom));
      @(negedge clk);
      if (i == 0) chk("t2_first", req0_ready, 1);
      if (i == 1) chk("t2_second", RR ? req1_ready : req0_ready, 1);
      next();
    end
    drive(0, 0, 0, 1, 0, 8'h77);
    @(negedge clk); chk("t2_req1_alone", req1_ready, 1);
    next();

    // fill to full, then push blocked while pop proceeds
    do_reset();
    for (int i = 0; i < M; i++) begin
      drive(1, 0, 8'(i), 0, 0, 0);
      next();
    end
    drive(1, 0, 8'hEE, 1, 1, 0);
    @(negedge clk);
    chk("t3_full_level", level, M);
    chk("t3_push_blocked", req0_ready, 0);
    chk("t3_pop_granted", req1_ready, 1);
    next();
    drive(1, 0, 8'hEE, 0, 0, 0);
    @(negedge clk);
    chk("t3_level127", level, M - 1);
    chk("t3_push_now", req0_ready, 1);
    next();

    // empty: pop blocked, push granted, then pop returns it
    do_reset();
    drive(1, 1, 0, 1, 0, 8'hA5);
    @(negedge clk);
    chk("t4_pop_blocked", req0_ready, 0);
    chk("t4_push_granted", req1_ready, 1);
    next();
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk); chk("t4_pop_granted", req0_ready, 1);
    next();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_rsp0", rsp0_valid, 1);
    chk("t4_data", rsp_data, 8'hA5);
    next();

    // reset lands on an in-flight response
    do_reset();
    drive(0, 0, 0, 1, 0, 8'h5A);
    next();
    drive(0, 0, 0, 1, 1, 0);
    @(negedge clk); chk("t5_pop_granted", req1_ready, 1);
    next();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk); chk("t5_rsp_dropped", rsp1_valid, 0);
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 0);
    chk("t5_err", err, 0);
    chk("t5_rsp1", rsp1_valid, 0);
    next();

    // random traffic, alternating fill/drain bias
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pp = ((i / 250) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 99) < 70, !($urandom_range(0, 99) < pp), 8'($urandom),
            $urandom_range(0, 99) < 70, !($urandom_range(0, 99) < pp), 8'($urandom));
      next();
    end

    // spurious stack valid sets sticky err
    drive(0, 0, 0, 0, 0, 0);
    next();
    force_valid = 1'b1;
    next();
    force_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_err_sticky", err, 1);
      next();
    end
    do_reset();
    @(negedge clk); chk("t6_err_cleared", err, 0);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
